// File: rtl/gg_patch_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : gg_patch_engine_if
//  Brief    : CPU ROM read-path bundle between the CPU side and the Game
//             Genie patch engine (address, read pulse, ROM byte in, byte out).
//  Revision : 1.0 - initial release
// ============================================================================
interface gg_patch_engine_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rd;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              hit;

    // CPU / ROM side: presents the read and the original byte, consumes the result
    modport master (
        output cpu_addr,
        output cpu_rd,
        output data_in,
        input  data_out,
        input  hit
    );

    // Patch engine side
    modport slave (
        input  cpu_addr,
        input  cpu_rd,
        input  data_in,
        output data_out,
        output hit
    );
endinterface
`default_nettype wire

// File: rtl/gg_patch_engine.sv
`default_nettype none
// ============================================================================
//  Module   : gg_patch_engine
//  Brief    : Game Genie cheat table sitting on the Z80 ROM read-data path.
//             Holds up to NUM_CODES {addr, cmp, rep} entries and substitutes
//             the replace byte when the CPU reads a matching address.
//  Options  : GG_COMPARE_EN - when defined, entries with the compare flag
//             only patch if the original ROM byte equals the compare value.
//  Revision : 1.0 - initial release
// ============================================================================
module gg_patch_engine #(
    parameter int NUM_CODES = 16,
    parameter int ADDR_W    = 16
) (
    input  wire logic                           clk_sys,
    input  wire logic                           reset,
    input  wire logic                           enable,
    input  wire logic                           code_clear,
    input  wire logic [128:0]                   code_in,
    gg_patch_engine_if.slave                    bus,
    output logic [$clog2(NUM_CODES+1)-1:0]      code_count,
    output logic                                overflow
);

    localparam int C_IDX_W = $clog2(NUM_CODES);
    localparam int C_CNT_W = $clog2(NUM_CODES + 1);
    localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(NUM_CODES);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Code word fields
    // ------------------------------------------------------------------
    logic              w_strobe;
    logic [ADDR_W-1:0] w_code_addr;
    logic [7:0]        w_code_rep;
    logic              unused_code_bits;

    assign w_strobe    = code_in[128];
    assign w_code_addr = code_in[64 +: ADDR_W];
    assign w_code_rep  = code_in[7:0];
    // Most of the 129-bit word carries nothing this engine needs
    assign unused_code_bits = ^code_in;

`ifdef GG_COMPARE_EN
    logic [7:0] w_code_cmp;
    logic       w_code_cmpen;
    assign w_code_cmp   = code_in[39:32];
    assign w_code_cmpen = code_in[96];
`endif

    // ------------------------------------------------------------------
    // Slot table
    // ------------------------------------------------------------------
    logic [NUM_CODES-1:0] slot_valid_q;
    logic [ADDR_W-1:0]    slot_addr_q [NUM_CODES];
    logic [7:0]           slot_rep_q  [NUM_CODES];
`ifdef GG_COMPARE_EN
    logic [7:0]           slot_cmp_q   [NUM_CODES];
    logic                 slot_cmpen_q [NUM_CODES];
`endif

    // Per-slot address comparators for both the CPU read and the loader
    logic [NUM_CODES-1:0] w_rd_match;
    logic [NUM_CODES-1:0] w_ld_match;

    generate
        for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_slot_cmp
            assign w_rd_match[gi] = slot_valid_q[gi] && (slot_addr_q[gi] == bus.cpu_addr);
            assign w_ld_match[gi] = slot_valid_q[gi] && (slot_addr_q[gi] == w_code_addr);
        end
    endgenerate

    // Lowest-index priority encode of both match vectors
    logic               w_rd_any;
    logic [C_IDX_W-1:0] w_rd_idx;
    logic               w_ld_any;
    logic [C_IDX_W-1:0] w_ld_idx;

    // Scan downward so the lowest matching slot is the last one assigned
    always_comb begin
        w_rd_any = |w_rd_match;
        w_ld_any = |w_ld_match;
        w_rd_idx = '0;
        w_ld_idx = '0;
        for (int i = NUM_CODES - 1; i >= 0; i--) begin
            if (w_rd_match[i]) w_rd_idx = C_IDX_W'(i);
            if (w_ld_match[i]) w_ld_idx = C_IDX_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // Load control (state tracks code_count: 0 / 1..N-1 / N)
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               w_wr_en;
    logic [C_IDX_W-1:0] w_wr_idx;

    // Next count/overflow/state and slot write select; clear beats a strobe
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        w_wr_en    = 1'b0;
        w_wr_idx   = '0;
        state_d    = state_q;

        if (code_clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (w_strobe) begin
            if (w_ld_any) begin
                // Re-loading an existing address updates it in place
                w_wr_en  = 1'b1;
                w_wr_idx = w_ld_idx;
            end else if (state_q != FULL) begin
                w_wr_en  = 1'b1;
                w_wr_idx = count_q[C_IDX_W-1:0];
                count_d  = count_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (count_d == '0)             state_d = EMPTY;
        else if (count_d == C_FULL_CNT) state_d = FULL;
        else                           state_d = PARTIAL;
    end

    // Load state, occupancy count and sticky overflow
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Slot storage; only the valid bits need clearing
    always_ff @(posedge clk_sys) begin
        if (reset || code_clear) begin
            slot_valid_q <= '0;
        end else if (w_wr_en) begin
            slot_valid_q[w_wr_idx] <= 1'b1;
            slot_addr_q[w_wr_idx]  <= w_code_addr;
            slot_rep_q[w_wr_idx]   <= w_code_rep;
`ifdef GG_COMPARE_EN
            slot_cmp_q[w_wr_idx]   <= w_code_cmp;
            slot_cmpen_q[w_wr_idx] <= w_code_cmpen;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline: capture the winning slot on each new read
    // ------------------------------------------------------------------
    logic       hit_q;
    logic [7:0] rep_q;
`ifdef GG_COMPARE_EN
    logic [7:0] cmp_q;
    logic       cmpen_q;
`endif

    // Lookup registers hold until the next cpu_rd
    always_ff @(posedge clk_sys) begin
        if (reset || code_clear) begin
            hit_q   <= 1'b0;
            rep_q   <= '0;
`ifdef GG_COMPARE_EN
            cmp_q   <= '0;
            cmpen_q <= 1'b0;
`endif
        end else if (bus.cpu_rd) begin
            hit_q   <= enable & w_rd_any;
            rep_q   <= slot_rep_q[w_rd_idx];
`ifdef GG_COMPARE_EN
            cmp_q   <= slot_cmp_q[w_rd_idx];
            cmpen_q <= slot_cmpen_q[w_rd_idx];
`endif
        end
    end

    // Output mux; enable gates immediately so a disable never waits for a read
    logic w_patch;
    always_comb begin
`ifdef GG_COMPARE_EN
        w_patch = hit_q & enable & (~cmpen_q | (bus.data_in == cmp_q));
`else
        w_patch = hit_q & enable;
`endif
        bus.data_out = w_patch ? rep_q : bus.data_in;
        bus.hit      = w_patch;
    end

    assign code_count = count_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_gg_patch_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gg_patch_engine
//  Brief    : Directed self-checking bench for gg_patch_engine. Expected read
//             results are queued when a read is issued and compared when the
//             lookup result is due one cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gg_patch_engine;

    localparam int NUM_CODES = 16;
    localparam int ADDR_W    = 16;

    logic         clk_sys    = 1'b0;
    logic         reset      = 1'b1;
    logic         enable     = 1'b1;
    logic         code_clear = 1'b0;
    logic [128:0] code_in    = '0;
    logic [4:0]   code_count;
    logic         overflow;

    gg_patch_engine_if #(.ADDR_W(ADDR_W)) bus ();

    gg_patch_engine #(
        .NUM_CODES (NUM_CODES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .enable     (enable),
        .code_clear (code_clear),
        .code_in    (code_in),
        .bus        (bus),
        .code_count (code_count),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       hit;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one strobed code word; ignored flag and upper address bits are set to ones
    task automatic load(input logic [15:0] a, input logic [7:0] cmp, input logic [7:0] rep,
                        input bit cmpen, input bit clr);
        @(negedge clk_sys);
        code_in          = '0;
        code_in[128]     = 1'b1;
        code_in[127:97]  = '1;
        code_in[96]      = cmpen;
        code_in[95:80]   = 16'hFFFF;
        code_in[79:64]   = a;
        code_in[63:40]   = '1;
        code_in[39:32]   = cmp;
        code_in[31:8]    = '1;
        code_in[7:0]     = rep;
        code_clear       = clr;
        @(negedge clk_sys);
        code_in[128]     = 1'b0;
        code_clear       = 1'b0;
    endtask

    task automatic clear_table();
        @(negedge clk_sys);
        code_clear = 1'b1;
        @(negedge clk_sys);
        code_clear = 1'b0;
    endtask

    // Issue a read, queue its expectation, then check it one cycle later
    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] din,
                      input logic [7:0] exp_d, input logic exp_h);
        exp_t e;
        @(negedge clk_sys);
        bus.cpu_addr = a;
        bus.data_in  = din;
        bus.cpu_rd   = 1'b1;
        sb.push_back('{tag, exp_d, exp_h});
        @(negedge clk_sys);
        bus.cpu_rd   = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_data"}, 32'(bus.data_out), 32'(e.data));
            chk({e.tag, "_hit"},  32'(bus.hit),      32'(e.hit));
        end
    endtask

    initial begin
        bus.cpu_addr = '0;
        bus.cpu_rd   = 1'b0;
        bus.data_in  = 8'h5A;

        // Reset state
        repeat (2) @(negedge clk_sys);
        chk("rst_count", 32'(code_count), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_hit",   32'(bus.hit), 0);
        chk("rst_data",  32'(bus.data_out), 32'h5A);
        reset = 1'b0;

        // Basic patch and neighbour address
        load(16'h1234, 8'h00, 8'hAA, 1'b0, 1'b0);
        chk("basic_count", 32'(code_count), 1);
        rd("basic_hit",  16'h1234, 8'h55, 8'hAA, 1'b1);
        rd("basic_miss", 16'h1235, 8'h55, 8'h55, 1'b0);

        // Compare-gated code
        load(16'h0100, 8'h3E, 8'h00, 1'b1, 1'b0);
        rd("cmp_eq", 16'h0100, 8'h3E, 8'h00, 1'b1);
`ifdef GG_COMPARE_EN
        rd("cmp_ne", 16'h0100, 8'h3F, 8'h3F, 1'b0);
`else
        rd("cmp_ne", 16'h0100, 8'h3F, 8'h00, 1'b1);
`endif

        // Overwrite in place
        load(16'h2000, 8'h00, 8'h11, 1'b0, 1'b0);
        load(16'h2000, 8'h00, 8'h22, 1'b0, 1'b0);
        chk("ovw_count", 32'(code_count), 3);
        rd("ovw_read", 16'h2000, 8'h77, 8'h22, 1'b1);

        // Enable gating: immediate on the held read, then on the next reads
        rd("en_pre", 16'h1234, 8'h55, 8'hAA, 1'b1);
        @(negedge clk_sys);
        enable = 1'b0;
        #1;
        chk("en_off_data", 32'(bus.data_out), 32'h55);
        chk("en_off_hit",  32'(bus.hit), 0);
        rd("en_off_read", 16'h1234, 8'h55, 8'h55, 1'b0);
        @(negedge clk_sys);
        enable = 1'b1;
        #1;
        chk("en_back_held", 32'(bus.data_out), 32'h55);
        rd("en_on_read", 16'h1234, 8'h55, 8'hAA, 1'b1);

        // Clear empties the table
        clear_table();
        chk("clr_count", 32'(code_count), 0);
        rd("clr_read", 16'h1234, 8'h55, 8'h55, 1'b0);

        // Fill the table, then overflow
        for (int i = 0; i < NUM_CODES; i++)
            load(16'h3000 + 16'(i), 8'h00, 8'(i + 1), 1'b0, 1'b0);
        chk("full_count", 32'(code_count), NUM_CODES);
        chk("full_ovf0",  32'(overflow), 0);
        load(16'h4000, 8'h00, 8'hEE, 1'b0, 1'b0);
        chk("ovf_count", 32'(code_count), NUM_CODES);
        chk("ovf_flag",  32'(overflow), 1);
        rd("ovf_drop",  16'h4000, 8'h99, 8'h99, 1'b0);
        rd("full_first", 16'h3000, 8'h99, 8'h01, 1'b1);
        rd("full_last",  16'h300F, 8'h99, 8'h10, 1'b1);
        load(16'h3005, 8'h00, 8'h77, 1'b0, 1'b0);
        chk("full_ovw_count", 32'(code_count), NUM_CODES);
        chk("full_ovw_ovf",   32'(overflow), 1);
        rd("full_ovw_read", 16'h3005, 8'h99, 8'h77, 1'b1);

        clear_table();
        chk("clr2_count", 32'(code_count), 0);
        chk("clr2_ovf",   32'(overflow), 0);
        rd("clr2_read", 16'h3000, 8'h99, 8'h99, 1'b0);

        // Strobe together with clear: clear wins
        load(16'h6000, 8'h00, 8'h66, 1'b0, 1'b0);
        chk("sc_pre_count", 32'(code_count), 1);
        load(16'h5000, 8'h00, 8'h55, 1'b0, 1'b1);
        chk("sc_count", 32'(code_count), 0);
        rd("sc_new", 16'h5000, 8'h12, 8'h12, 1'b0);
        rd("sc_old", 16'h6000, 8'h12, 8'h12, 1'b0);

        // Reset in the middle of a patched read
        load(16'h1234, 8'h00, 8'hAA, 1'b0, 1'b0);
        load(16'h7000, 8'h00, 8'hBB, 1'b0, 1'b0);
        rd("mid_pre", 16'h1234, 8'h55, 8'hAA, 1'b1);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("mid_rst_data",  32'(bus.data_out), 32'h55);
        chk("mid_rst_hit",   32'(bus.hit), 0);
        chk("mid_rst_count", 32'(code_count), 0);
        reset = 1'b0;
        rd("mid_after_a", 16'h1234, 8'h55, 8'h55, 1'b0);
        rd("mid_after_b", 16'h7000, 8'h44, 8'h44, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Run-length bound
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
